// File: rtl/usr_mem_responder.sv
// Purpose: single-port-style RAM responder with independent write-burst and read-burst engines.
// Latency: write beat lands the cycle it is accepted; read data appears 2 cycles after rstart, then streams.
// Backpressure: writes stall on wdata_vld=0 while wready holds; reads stream with no backpressure.
module usr_mem_responder #(
    parameter int WDATA_WIDTH = 64,
    parameter int RDATA_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int MEM_DEPTH   = 1024
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wstart,
    output logic                   wready,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [LEN_WIDTH-1:0]   wdata_len,
    input  logic                   wdata_vld,
    input  logic [WDATA_WIDTH-1:0] wdata,
    input  logic                   rstart,
    output logic                   rready,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    input  logic [LEN_WIDTH-1:0]   rdata_len,
    output logic                   rdata_vld,
    output logic [RDATA_WIDTH-1:0] rdata,
    output logic                   wdone,
    output logic                   rdone
);
    localparam int BYTES = WDATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [LEN_WIDTH-1:0] BEAT_ROUND = LEN_WIDTH'(BYTES - 1);

    typedef enum logic {W_IDLE, W_DATA} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} r_state_e;

    logic [WDATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Beat counts round up and wrap in LEN_WIDTH arithmetic, matching the length field width.
    logic [LEN_WIDTH-1:0] wlen_rnd, rlen_rnd, wbeats, rbeats;
    logic [IDX_W-1:0]     waddr_idx, raddr_idx;
    assign wlen_rnd  = wdata_len + BEAT_ROUND;
    assign rlen_rnd  = rdata_len + BEAT_ROUND;
    assign wbeats    = wlen_rnd >> OFF_W;
    assign rbeats    = rlen_rnd >> OFF_W;
    assign waddr_idx = waddr[OFF_W +: IDX_W];
    assign raddr_idx = raddr[OFF_W +: IDX_W];

    // Byte-offset and above-depth address bits do not select a word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{waddr[OFF_W-1:0], waddr[ADDR_WIDTH-1:OFF_W+IDX_W],
                                raddr[OFF_W-1:0], raddr[ADDR_WIDTH-1:OFF_W+IDX_W]};

    w_state_e             w_state_q, w_state_d;
    logic [IDX_W-1:0]     w_idx_q, w_idx_d;
    logic [LEN_WIDTH-1:0] w_cnt_q, w_cnt_d;
    logic                 wready_q, wready_d;
    logic                 wdone_q, wdone_d;
    logic                 mem_we;

    r_state_e             r_state_q, r_state_d;
    logic [IDX_W-1:0]     r_idx_q, r_idx_d;
    logic [LEN_WIDTH-1:0] r_cnt_q, r_cnt_d;
    logic                 rready_q, rready_d;
    logic                 rdone_q, rdone_d;
    logic                 rdata_vld_q, rdata_vld_d;
    logic [RDATA_WIDTH-1:0] rdata_q, rdata_d;

    // Write engine: latch burst on wstart, accept one beat per valid cycle, count down remaining beats.
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        wdone_d   = 1'b0;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (wstart && (wbeats != '0)) begin
                    w_state_d = W_DATA;
                    w_idx_d   = waddr_idx;
                    w_cnt_d   = wbeats;
                end
            end
            W_DATA: begin
                if (wdata_vld) begin
                    mem_we  = 1'b1;
                    w_idx_d = w_idx_q + 1'b1;
                    w_cnt_d = w_cnt_q - 1'b1;
                    if (w_cnt_q == LEN_WIDTH'(1)) begin
                        w_state_d = W_IDLE;
                        wdone_d   = 1'b1;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        wready_d = (w_state_d == W_DATA);
    end

    // Read engine: issue one RAM read per cycle for N cycles, then one drain cycle for the last beat.
    always_comb begin
        r_state_d   = r_state_q;
        r_idx_d     = r_idx_q;
        r_cnt_d     = r_cnt_q;
        rdone_d     = 1'b0;
        rdata_vld_d = 1'b0;
        rdata_d     = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (rstart && (rbeats != '0)) begin
                    r_state_d = R_RUN;
                    r_idx_d   = raddr_idx;
                    r_cnt_d   = rbeats;
                end
            end
            R_RUN: begin
                rdata_vld_d = 1'b1;
                rdata_d     = RDATA_WIDTH'(mem[r_idx_q]);
                r_idx_d     = r_idx_q + 1'b1;
                r_cnt_d     = r_cnt_q - 1'b1;
                if (r_cnt_q == LEN_WIDTH'(1)) begin
                    r_state_d = R_DRAIN;
                    rdone_d   = 1'b1;
                end
            end
            R_DRAIN: r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        rready_d = (r_state_d == R_IDLE);
    end

    // Control and output registers; reset aborts both engines immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_cnt_q     <= '0;
            wready_q    <= 1'b0;
            wdone_q     <= 1'b0;
            r_state_q   <= R_IDLE;
            r_idx_q     <= '0;
            r_cnt_q     <= '0;
            rready_q    <= 1'b1;
            rdone_q     <= 1'b0;
            rdata_vld_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            w_state_q   <= w_state_d;
            w_idx_q     <= w_idx_d;
            w_cnt_q     <= w_cnt_d;
            wready_q    <= wready_d;
            wdone_q     <= wdone_d;
            r_state_q   <= r_state_d;
            r_idx_q     <= r_idx_d;
            r_cnt_q     <= r_cnt_d;
            rready_q    <= rready_d;
            rdone_q     <= rdone_d;
            rdata_vld_q <= rdata_vld_d;
            rdata_q     <= rdata_d;
        end
    end

    // RAM write port; a same-cycle read of this word sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[w_idx_q] <= wdata;
        end
    end

    assign wready    = wready_q;
    assign wdone     = wdone_q;
    assign rready    = rready_q;
    assign rdone     = rdone_q;
    assign rdata_vld = rdata_vld_q;
    assign rdata     = rdata_q;
endmodule

// File: tb/tb_usr_mem_responder.sv
// Bench for usr_mem_responder: directed bursts, expected read beats queued at issue, popped by a monitor.
module tb_usr_mem_responder;
    logic        clk;
    logic        rstn;
    logic        wstart, wready, wdata_vld;
    logic [31:0] waddr, raddr;
    logic [15:0] wdata_len, rdata_len;
    logic [63:0] wdata, rdata;
    logic        rstart, rready, rdata_vld, wdone, rdone;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model [1024];

    usr_mem_responder dut (
        .clk(clk), .rstn(rstn),
        .wstart(wstart), .wready(wready), .waddr(waddr), .wdata_len(wdata_len),
        .wdata_vld(wdata_vld), .wdata(wdata),
        .rstart(rstart), .rready(rready), .raddr(raddr), .rdata_len(rdata_len),
        .rdata_vld(rdata_vld), .rdata(rdata),
        .wdone(wdone), .rdone(rdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every presented read beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (rstn && rdata_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdata_unexpected got %h want no beat", rdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL rdata_beat got %h want %h", rdata, e);
                end
            end
            if (rdone) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL rdone_early got %0d beats left want 0", exp_q.size());
                end
            end
        end
    end

    task automatic write_burst(input logic [31:0] a, input logic [15:0] len,
                               input logic [63:0] base, input bit gap);
        int n, beat, c, idx;
        n    = (int'(len) + 7) / 8;
        idx  = int'(a[12:3]);
        beat = 0;
        c    = 0;
        @(posedge clk); #1;
        wstart = 1'b1; waddr = a; wdata_len = len;
        @(posedge clk); #1;
        wstart = 1'b0;
        while (beat < n) begin
            wdata_vld = gap ? (c % 2 == 0) : 1'b1;
            wdata     = wdata_vld ? base + 64'(beat) : 64'hDEAD_0000_0000_0000 | 64'(c);
            @(negedge clk);
            chk("wready_busy", 64'(wready), 64'd1);
            chk("wdone_busy", 64'(wdone), 64'd0);
            if (wdata_vld) begin
                model[idx % 1024] = wdata;
                idx++;
                beat++;
            end
            c++;
            @(posedge clk); #1;
        end
        // A beat offered after completion must be ignored.
        wdata_vld = 1'b1;
        wdata     = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        chk("wready_end", 64'(wready), 64'd0);
        chk("wdone_pulse", 64'(wdone), 64'd1);
        @(posedge clk); #1;
        wdata_vld = 1'b0;
        @(negedge clk);
        chk("wdone_clear", 64'(wdone), 64'd0);
    endtask

    task automatic read_burst(input logic [31:0] a, input logic [15:0] len,
                              input int abort_k, input int poke_k);
        int n;
        logic [63:0] last;
        n    = (int'(len) + 7) / 8;
        last = '0;
        for (int i = 0; i < n; i++) begin
            last = model[(int'(a[12:3]) + i) % 1024];
            exp_q.push_back(last);
        end
        @(posedge clk); #1;
        rstart = 1'b1; raddr = a; rdata_len = len;
        for (int k = 1; k <= n + 2; k++) begin
            @(posedge clk); #1;
            rstart    = (k == poke_k);
            raddr     = 32'h0;
            rdata_len = 16'd64;
            if (k == abort_k) begin
                rstn = 1'b0;
                exp_q.delete();
                #1;
                chk("abort_vld", 64'(rdata_vld), 64'd0);
                chk("abort_rready", 64'(rready), 64'd1);
                chk("abort_rdone", 64'(rdone), 64'd0);
                @(negedge clk); #2;
                rstn = 1'b1;
                return;
            end
            @(negedge clk);
            chk("rready_t", 64'(rready), 64'(k == n + 2));
            chk("rvld_t", 64'(rdata_vld), 64'(k >= 2 && k <= n + 1));
            chk("rdone_t", 64'(rdone), 64'(k == n + 1));
        end
        chk("rdata_hold", rdata, last);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = '0;
        rstn = 1'b0;
        wstart = 1'b0; waddr = '0; wdata_len = '0; wdata_vld = 1'b0; wdata = '0;
        rstart = 1'b0; raddr = '0; rdata_len = '0;
        #12;
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_rready", 64'(rready), 64'd1);
        chk("rst_rvld", 64'(rdata_vld), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_wdone", 64'(wdone), 64'd0);
        chk("rst_rdone", 64'(rdone), 64'd0);
        @(negedge clk); #2;
        rstn = 1'b1;

        // 128-beat write/readback at word 64.
        write_burst(32'h8000_0200, 16'd1024, 64'd0, 1'b0);
        read_burst(32'h8000_0200, 16'd1024, 0, 0);

        // Index wraps 1020..1023 -> 0..3.
        write_burst(32'h0000_1FE0, 16'd64, 64'hA0, 1'b0);
        read_burst(32'h0000_1FE0, 16'd64, 0, 0);

        // Gapped valid: 4 writes; word 68 keeps its old value. rstart while running is ignored.
        write_burst(32'h0000_0200, 16'd32, 64'h50, 1'b1);
        read_burst(32'h0000_0200, 16'd40, 0, 3);

        // Zero-length commands do nothing.
        @(posedge clk); #1;
        wstart = 1'b1; waddr = 32'h0; wdata_len = 16'd0;
        rstart = 1'b1; raddr = 32'h0; rdata_len = 16'd0;
        @(posedge clk); #1;
        wstart = 1'b0; rstart = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("len0_wready", 64'(wready), 64'd0);
            chk("len0_wdone", 64'(wdone), 64'd0);
            chk("len0_rready", 64'(rready), 64'd1);
            chk("len0_rdone", 64'(rdone), 64'd0);
            @(posedge clk); #1;
        end

        // Reset at beat 50 of a 128-beat read, then a clean full read.
        read_burst(32'h8000_0200, 16'd1024, 52, 0);
        @(negedge clk);
        chk("post_abort_vld", 64'(rdata_vld), 64'd0);
        chk("post_abort_rdata", rdata, 64'd0);
        read_burst(32'h8000_0200, 16'd1024, 0, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usr_mem_responder.md
USR_MEM_RESPONDER -- requirements
Module: usr_mem_responder

Interface
REQ-001 SHALL have parameter WDATA_WIDTH, default 64, meaning write beat width in bits.
REQ-002 SHALL have parameter RDATA_WIDTH, default 64, meaning read beat width in bits; it SHALL equal WDATA_WIDTH.
REQ-003 SHALL have parameters ADDR_WIDTH (32, byte address width), LEN_WIDTH (16, burst length width in bytes) and MEM_DEPTH (1024, power-of-2 word count of internal RAM).
REQ-004 SHALL have ports clk (input, 1, single clock) and rstn (input, 1, asynchronous active-low reset).
REQ-005 SHALL have write ports: wstart in 1 command pulse; wready out 1 write data window; waddr in ADDR_WIDTH start byte address; wdata_len in LEN_WIDTH length in bytes; wdata_vld in 1 beat valid; wdata in WDATA_WIDTH beat data.
REQ-006 SHALL have read ports: rstart in 1 command pulse; rready out 1 read engine idle; raddr in ADDR_WIDTH; rdata_len in LEN_WIDTH; rdata_vld out 1; rdata out RDATA_WIDTH.
REQ-007 SHALL have status outputs wdone (1, one-cycle pulse) and rdone (1, one-cycle pulse).

Function
REQ-008 SHALL size each beat as BYTES = WDATA_WIDTH/8; beat count N = ceil(len/BYTES) in LEN_WIDTH-bit arithmetic.
REQ-009 SHALL map a byte address to word index (addr >> log2(BYTES)) mod MEM_DEPTH; index SHALL increment by 1 per beat and wrap from MEM_DEPTH-1 to 0.
REQ-010 Write FSM states W_IDLE, W_DATA; wstart=1 in W_IDLE with N>0 SHALL latch index and N and enter W_DATA next cycle.
REQ-011 wready SHALL be 1 exactly while in W_DATA, registered.
REQ-012 In W_DATA each cycle with wdata_vld=1 SHALL write wdata to RAM at current index; cycles with wdata_vld=0 SHALL write nothing and not advance.
REQ-013 On the N-th accepted beat the FSM SHALL return to W_IDLE (wready=0 next cycle) and pulse wdone on that next cycle; wdata_vld while in W_IDLE SHALL be ignored.
REQ-014 wstart in W_DATA SHALL be ignored; wstart with N=0 SHALL be ignored, no wdone.
REQ-015 Read FSM states R_IDLE, R_RUN, R_DRAIN; rready SHALL be 1 only in R_IDLE.
REQ-016 rstart=1 in R_IDLE with N>0 at cycle T SHALL enter R_RUN at T+1, issuing one RAM read per cycle for N consecutive cycles, no gaps, no backpressure.
REQ-017 RAM read latency SHALL be 1 cycle: first rdata_vld=1 at T+2, N consecutive beats, rdata registered with rdata_vld.
REQ-018 After last issue SHALL pass R_DRAIN for one cycle, return to R_IDLE with rready=1 the cycle after the last rdata_vld, and pulse rdone concurrently with the last rdata_vld beat.
REQ-019 rstart outside R_IDLE or with N=0 SHALL be ignored.
REQ-020 Write and read engines SHALL operate concurrently; same index written and read in one cycle SHALL return the old (pre-write) data.
REQ-021 rdata SHALL hold its last value when rdata_vld=0.

Reset
REQ-022 rstn=0 SHALL asynchronously force W_IDLE, R_IDLE, wready=0, rready=1, rdata_vld=0, rdata=0, wdone=0, rdone=0, counters and latched index/N to 0.
REQ-023 Reset mid-burst SHALL abort both engines with no further RAM writes or rdata_vld; RAM contents need not be cleared.

Verification
REQ-024 Write waddr=0x8000_0200, wdata_len=1024, 128 beats data 0..127 -> wready rises cycle after wstart, words 64..191 hold 0..127, wdone one cycle after beat 127, wready low.
REQ-025 Then rstart raddr=0x8000_0200, rdata_len=1024 at T -> rdata_vld high T+2..T+129, rdata 0..127, rdone at T+129, rready 0 from T+1 to T+129 and 1 at T+130.
REQ-026 Wrap: write index 1020 (waddr=0x1FE0), len 64, data 0xA0..0xA7 -> words 1020..1023,0..3; readback matches in order.
REQ-027 Gapped wdata_vld (every other cycle) len 32 -> exactly 4 writes, wdone after 4th valid beat; wstart/rstart with len 0 and rstart during R_RUN -> no state change, no pulses.
REQ-028 rstn low at beat 50 of 128-beat read -> rdata_vld=0 immediately, rready=1, no rdone; subsequent read returns correct data.
